hash160_sched: RTL
==================

Name: hash160_sched

Overview:
- Round-robin scheduler that shares one Hash160 core (SHA-256 followed by RIPEMD-160) between NREQ requesters.
- Grants one requester at a time and streams that requester's 64-byte pre-padded block into a 512-bit staging register.
- Starts the core, waits for completion with a timeout guard, then returns the 160-bit digest to the granted requester.
- Sits between the host-side byte streams and the hash core.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 255, max cycles in WAIT before error (1..65535).
- CNT_W, 16, timer width; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester byte valid.
- req_byte  in  NREQ*8  per-requester byte; requester i uses bits [8i+7:8i].
- req_ready  out  NREQ  byte accepted from requester i when req_valid[i] & req_ready[i].
- rsp_valid  out  NREQ  one-cycle pulse to the requester whose job finished.
- rsp_digest  out  160  digest; held until the next response.
- rsp_err  out  1  1 = timeout; qualified by rsp_valid.
- busy  out  1  high in every state except IDLE.
- core_start  out  1  one-cycle start pulse to the core.
- core_block  out  512  staged block; byte 0 in [511:504].
- core_done  in  1  core completion pulse.
- core_digest  in  160  core result; valid with core_done.

Behaviour:
- Reset values (asserted anytime, including mid-job):
  - Go to IDLE.
  - req_ready=0, rsp_valid=0, core_start=0, busy=0, rsp_err=0.
  - rsp_digest=0, core_block=0, byte counter=0, timer=0.
  - last_grant=NREQ-1, so requester 0 wins first.
  - An in-flight job is dropped; no response is issued.
- States: IDLE, LOAD, START, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant the first asserted index searching upward from last_grant+1, wrapping.
  - Latch grant, clear the counter, go to LOAD.
  - No byte is accepted in this cycle.
- LOAD:
  - req_ready[grant]=1; all other ready bits are 0.
  - On handshake, write req_byte[grant] to byte slot cnt (slot k occupies [511-8k:504-8k]) and increment cnt.
  - Invalid cycles stall; there is no abort.
  - The handshake with cnt==63 moves to START.
  - req_valid from non-granted requesters is ignored. They keep waiting; no byte is lost because ready stays 0.
- START:
  - core_start=1 for exactly this cycle.
  - core_block is stable from START until leaving WAIT.
  - Clear timer, go to WAIT.
- WAIT:
  - If core_done: capture core_digest into rsp_digest, set rsp_err=0, go to RESP.
  - Otherwise increment the timer. At timer==TIMEOUT-1 with no done: set rsp_digest=0, rsp_err=1, go to RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - rsp_valid[grant]=1 for one cycle.
  - Set last_grant=grant, go to IDLE.
- core_done outside WAIT is ignored.
- Latency:
  - Minimum request-to-start is 66 cycles: 1 grant + 64 bytes + START.
  - rsp_valid rises the cycle after the cycle in which core_done was sampled.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NREQ-1,0.
- busy=1 in LOAD, START, WAIT and RESP.

Decomposition:
- Shared package hash160_pkg holds:
  - State enum.
  - BLOCK_BYTES=64, BLOCK_W=512, DIGEST_W=160.
  - Byte-slot index function.
- One sub-module, rr_arbiter: inputs req[NREQ] and last[$clog2(NREQ)]; outputs a one-hot grant, a grant index and any.
- Counter, timer and staging register stay in hash160_sched.

Test Plan:
- Single job:
  - Stimulus: requester 0 sends bytes 0x00..0x3F back-to-back; core model pulses done 10 cycles after start with digest 160'h0123...CDEF.
  - Response: core_start 65 cycles after grant. core_block[511:504]=8'h00 and [7:0]=8'h3F. rsp_valid=2'b01 one cycle after done. rsp_digest equals the model digest, rsp_err=0.
- Contention:
  - Stimulus: both requesters' valid held high from reset.
  - Response: requester 0 is served first, then 1, then 0. req_ready[1] stays 0 throughout job 0.
- Stalls:
  - Stimulus: requester 1 drops valid every other cycle.
  - Response: exactly 64 bytes captured in order; core_start delayed accordingly; no duplicate or lost bytes.
- Timeout:
  - Stimulus: TIMEOUT=8, core never asserts done.
  - Response: rsp_valid pulses 8 cycles after the WAIT entry, rsp_err=1, rsp_digest=0. The next request is served normally.
- Boundaries:
  - Stimulus: core_done raised while in LOAD, then done on the final WAIT cycle.
  - Response: the stray done is ignored; the final done yields rsp_err=0.
- Mid-job reset:
  - Stimulus: rst asserted in WAIT.
  - Response: all outputs return to reset values immediately. The late core_done produces no rsp_valid, and requester 0 is granted first after release.

Source files
------------

// File: rtl/hash160_pkg.sv
// Shared types and constants for the Hash160 request scheduler.
package hash160_pkg;

    localparam int BLOCK_BYTES = 64;
    localparam int BLOCK_W     = 512;
    localparam int DIGEST_W    = 160;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Byte slot k sits at [511-8k -: 8], so byte 0 lands in the top byte.
    function automatic logic [8:0] slot_lsb(input logic [5:0] k);
        return 9'd504 - {k, 3'b000};
    endfunction

endpackage

// File: rtl/hash160_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request above the last grant, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_gnt_idx,
    output logic            o_any
);

    always_comb begin : p_search
        int c;
        c         = 0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            c = int'(i_last) + i;
            if (c >= NREQ) c = c - NREQ;
            if (!o_any && i_req[IW'(c)]) begin
                o_any     = 1'b1;
                o_gnt_idx = IW'(c);
            end
        end
        o_gnt = o_any ? (NREQ'(1) << o_gnt_idx) : '0;
    end

endmodule

// File: rtl/hash160_sched.sv
// Shares one Hash160 core among NREQ byte-stream requesters.
// state   | meaning
// IDLE    | arbitrate; LOAD | stream 64 bytes; START | pulse core_start
// WAIT    | await done or timeout; RESP | pulse rsp_valid to granted requester
module hash160_sched
    import hash160_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*8-1:0]     req_byte,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [DIGEST_W-1:0]   rsp_digest,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  core_start,
    output logic [BLOCK_W-1:0]    core_block,
    input  logic                  core_done,
    input  logic [DIGEST_W-1:0]   core_digest
);

    localparam int GW = $clog2(NREQ);

    state_t              r_state;
    logic [GW-1:0]       r_grant;
    logic [NREQ-1:0]     r_grant_oh;
    logic [GW-1:0]       r_last;
    logic [5:0]          r_cnt;
    logic [CNT_W-1:0]    r_timer;
    logic [BLOCK_W-1:0]  r_block;
    logic [DIGEST_W-1:0] r_digest;
    logic                r_err;

    logic [NREQ-1:0]     w_arb_oh;
    logic [GW-1:0]       w_arb_idx;
    logic                w_arb_any;
    logic [7:0]          w_byte;
    logic                w_hs;

    rr_arbiter #(.NREQ(NREQ), .IW(GW)) u_arb (
        .i_req     (req_valid),
        .i_last    (r_last),
        .o_gnt     (w_arb_oh),
        .o_gnt_idx (w_arb_idx),
        .o_any     (w_arb_any)
    );

    assign w_byte = req_byte[{r_grant, 3'b000} +: 8];
    assign w_hs   = (r_state == ST_LOAD) && req_valid[r_grant];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_last     <= GW'(NREQ - 1);
            r_cnt      <= '0;
            r_timer    <= '0;
            r_block    <= '0;
            r_digest   <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_grant    <= w_arb_idx;
                        r_grant_oh <= w_arb_oh;
                        r_cnt      <= '0;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_hs) begin
                        r_block[slot_lsb(r_cnt) +: 8] <= w_byte;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'(BLOCK_BYTES - 1)) r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the timeout cycle still counts as success.
                    if (core_done) begin
                        r_digest <= core_digest;
                        r_err    <= 1'b0;
                        r_state  <= ST_RESP;
                    end else if (r_timer == CNT_W'(TIMEOUT - 1)) begin
                        r_digest <= '0;
                        r_err    <= 1'b1;
                        r_state  <= ST_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_last  <= r_grant;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == ST_LOAD) ? r_grant_oh : '0;
    assign rsp_valid  = (r_state == ST_RESP) ? r_grant_oh : '0;
    assign core_start = (r_state == ST_START);
    assign busy       = (r_state != ST_IDLE);
    assign core_block = r_block;
    assign rsp_digest = r_digest;
    assign rsp_err    = r_err;

endmodule
